// File: rtl/instruction_memory.sv
// Instruction store for the fetch stage. A streamed program load fills the array, and
// combinational fetch reads are served once the load has completed (RUN).
module instruction_memory #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rd_enable,
   input  logic [31:0] i_addr,
   output logic [31:0] o_rd_data,
   output logic        o_fault,
   output logic        o_stall,
   input  logic        i_load_start,
   input  logic [31:0] i_load_len,
   input  logic        i_load_valid,
   input  logic [31:0] i_load_data,
   output logic        o_load_ready,
   output logic        o_load_done,
   output logic [15:0] o_fault_count
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   ptr_q, ptr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   len_eff;
   logic          done_d;
   logic          wr_en;
   logic [15:0]   fault_cnt_q;
   logic [AW-1:0] rd_idx;
   logic [31:0]   mem [DEPTH_WORDS];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Requested length is clamped so an oversized load fills the array and stops.
   assign len_eff = (i_load_len >= 32'(DEPTH_WORDS)) ? (AW+1)'(DEPTH_WORDS) : i_load_len[AW:0];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      len_d   = len_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE, RUN: begin
            if (i_load_start) begin
               ptr_d = '0;
               len_d = len_eff;
               if (len_eff == '0) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (i_load_valid) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + PTR_ONE;
               if (ptr_q == len_q - PTR_ONE) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         len_q       <= '0;
         o_load_done <= 1'b0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         len_q       <= len_d;
         o_load_done <= done_d;
         if (state_q == RUN && o_fault)
            fault_cnt_q <= sat_inc(fault_cnt_q);
      end
   end

   // Array has no reset so a program survives rst_n.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[ptr_q[AW-1:0]] <= i_load_data;
   end

   assign rd_idx        = i_addr[AW+1:2];
   assign o_fault       = i_rd_enable && ((i_addr[1:0] != 2'b00) || (i_addr >= 32'(4*DEPTH_WORDS)));
   assign o_rd_data     = (state_q == RUN && i_rd_enable && !o_fault) ? mem[rd_idx] : NOP_INST;
   assign o_stall       = (state_q != RUN);
   assign o_load_ready  = (state_q == LOAD);
   assign o_fault_count = fault_cnt_q;

endmodule
